// File: rtl/rotate_left_pipe.sv
// rotate_left_pipe: pipelined left rotator with valid/ready on both sides.
// Stage k rotates by 2^k when amount bit k is set. After SHW stages the word is
// rotated left by the full amount. Backpressure is elastic: a stage advances when
// it is empty or when the stage after it advances.
//
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   din/amount valid
//   in_ready   pipeline can accept (combinational through the ready chain)
//   amount     left-rotate distance, 0..WIDTH-1
//   din        word to rotate
//   out_valid  dout holds a result
//   out_ready  consumer takes dout
//   dout       din rotated left by amount
module rotate_left_pipe #(
    parameter int unsigned WIDTH = 32,   // must equal 2**SHW
    parameter int unsigned SHW   = 5     // rotate-amount width and stage count
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SHW-1:0]   amount,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout
);

    // Per-stage state
    logic [SHW-1:0]   v;
    logic [WIDTH-1:0] data [SHW];
    logic [SHW-1:0]   amt  [SHW];

    // Per-stage load sources and rotated data
    logic [SHW-1:0]   src_v;
    logic [WIDTH-1:0] src_data [SHW];
    logic [SHW-1:0]   src_amt  [SHW];
    logic [WIDTH-1:0] rot      [SHW];

    logic [SHW-1:0]   ready;
    logic             carry;

    // Stage 0 takes the input port; stage k takes stage k-1
    assign src_v[0]    = in_valid;
    assign src_data[0] = din;
    assign src_amt[0]  = amount;

    for (genvar k = 1; k < SHW; k++) begin : g_link
        assign src_v[k]    = v[k-1];
        assign src_data[k] = data[k-1];
        assign src_amt[k]  = amt[k-1];
    end

    // Stage k rotates by a fixed 2^k, selected by amount bit k
    for (genvar k = 0; k < SHW; k++) begin : g_rot
        localparam int unsigned STEP = 1 << k;
        assign rot[k] = src_amt[k][k]
                      ? {src_data[k][WIDTH-1-STEP:0], src_data[k][WIDTH-1:WIDTH-STEP]}
                      : src_data[k];
    end

    // Ready chain: a stage may load if it is empty or everything after it advances.
    // Built from a running carry so no signal depends on itself.
    always_comb begin
        carry = out_ready;
        ready = '0;
        for (int k = SHW - 1; k >= 0; k--) begin
            carry    = !v[k] | carry;
            ready[k] = carry;
        end
    end

    // Stage registers; a bubble loads v=0 and its data is don't-care
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v <= '0;
            for (int k = 0; k < SHW; k++) begin
                data[k] <= '0;
                amt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < SHW; k++) begin
                if (ready[k]) begin
                    v[k]    <= src_v[k];
                    data[k] <= rot[k];
                    amt[k]  <= src_amt[k];
                end
            end
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = v[SHW-1];
    assign dout      = data[SHW-1];

endmodule
